// File: rtl/bw_bbox_scanner.sv
// Bounding-box scanner for the 1-bit bw_image frame buffer.
// It sweeps the read port once in row-major order and reports the extent of all set pixels.
module bw_bbox_scanner #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int ADDR_W  = 17,
  parameter int COORD_W = 9,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               ack,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_data,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(IMG_H - 1);
  localparam logic [1:0]         DRAIN_LAST = 2'(RD_LAT);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [1:0]           drain_q, drain_d;

  logic [COORD_W-1:0]   wx_min_q, wx_min_d, wx_max_q, wx_max_d;
  logic [COORD_W-1:0]   wy_min_q, wy_min_d, wy_max_q, wy_max_d;
  logic                 wfound_q, wfound_d;

  logic [COORD_W-1:0]   ox_min_q, ox_min_d, ox_max_q, ox_max_d;
  logic [COORD_W-1:0]   oy_min_q, oy_min_d, oy_max_q, oy_max_d;
  logic                 ofound_q, ofound_d;

  // Coordinate/valid tuple delayed to line up with rd_data.
  logic [COORD_W-1:0]   px_q [RD_LAT];
  logic [COORD_W-1:0]   py_q [RD_LAT];
  logic                 pv_q [RD_LAT];

  logic                 hit;
  logic [COORD_W-1:0]   hx, hy;

  assign hit = pv_q[RD_LAT-1] && rd_data;
  assign hx  = px_q[RD_LAT-1];
  assign hy  = py_q[RD_LAT-1];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    x_d      = x_q;
    y_d      = y_q;
    drain_d  = drain_q;
    wx_min_d = wx_min_q;
    wx_max_d = wx_max_q;
    wy_min_d = wy_min_q;
    wy_max_d = wy_max_q;
    wfound_d = wfound_q;
    ox_min_d = ox_min_q;
    ox_max_d = ox_max_q;
    oy_min_d = oy_min_q;
    oy_max_d = oy_max_q;
    ofound_d = ofound_q;

    if (hit) begin
      if (hx < wx_min_q) wx_min_d = hx;
      if (hx > wx_max_q) wx_max_d = hx;
      if (hy < wy_min_q) wy_min_d = hy;
      if (hy > wy_max_q) wy_max_d = hy;
      wfound_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        addr_d   = '0;
        x_d      = '0;
        y_d      = '0;
        drain_d  = '0;
        wx_min_d = X_LAST;
        wy_min_d = Y_LAST;
        wx_max_d = '0;
        wy_max_d = '0;
        wfound_d = 1'b0;
        if (start) state_d = SCAN;
      end
      SCAN: begin
        if (addr_q == ADDR_LAST) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // One extra cycle past the read latency lets the last hit land in the working set.
        if (drain_q == DRAIN_LAST) begin
          state_d  = DONE;
          ofound_d = wfound_q;
          ox_min_d = wfound_q ? wx_min_q : '0;
          ox_max_d = wfound_q ? wx_max_q : '0;
          oy_min_d = wfound_q ? wy_min_q : '0;
          oy_max_d = wfound_q ? wy_max_q : '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      drain_q  <= '0;
      wx_min_q <= X_LAST;
      wx_max_q <= '0;
      wy_min_q <= Y_LAST;
      wy_max_q <= '0;
      wfound_q <= 1'b0;
      ox_min_q <= '0;
      ox_max_q <= '0;
      oy_min_q <= '0;
      oy_max_q <= '0;
      ofound_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      drain_q  <= drain_d;
      wx_min_q <= wx_min_d;
      wx_max_q <= wx_max_d;
      wy_min_q <= wy_min_d;
      wy_max_q <= wy_max_d;
      wfound_q <= wfound_d;
      ox_min_q <= ox_min_d;
      ox_max_q <= ox_max_d;
      oy_min_q <= oy_min_d;
      oy_max_q <= oy_max_d;
      ofound_q <= ofound_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q[0] <= '0;
      py_q[0] <= '0;
      pv_q[0] <= 1'b0;
    end else if (state_q == IDLE) begin
      px_q[0] <= '0;
      py_q[0] <= '0;
      pv_q[0] <= 1'b0;
    end else begin
      px_q[0] <= x_q;
      py_q[0] <= y_q;
      pv_q[0] <= (state_q == SCAN);
    end
  end

  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        px_q[gi] <= '0;
        py_q[gi] <= '0;
        pv_q[gi] <= 1'b0;
      end else if (state_q == IDLE) begin
        px_q[gi] <= '0;
        py_q[gi] <= '0;
        pv_q[gi] <= 1'b0;
      end else begin
        px_q[gi] <= px_q[gi-1];
        py_q[gi] <= py_q[gi-1];
        pv_q[gi] <= pv_q[gi-1];
      end
    end
  end

  assign rd_addr = addr_q;
  assign busy    = (state_q == SCAN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign found   = ofound_q;
  assign x_min   = ox_min_q;
  assign x_max   = ox_max_q;
  assign y_min   = oy_min_q;
  assign y_max   = oy_max_q;

endmodule

// File: tb/tb_bw_bbox_scanner.sv
// Scoreboard bench for bw_bbox_scanner on an 8x4 image, with RD_LAT=1 and RD_LAT=2 instances.
module tb_bw_bbox_scanner;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 5;
  localparam int CW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start1 = 1'b0, ack1 = 1'b0, start2 = 1'b0, ack2 = 1'b0;
  logic [AW-1:0] addr1, addr2;
  logic rd1, rd2a, rd2b;
  logic busy1, done1, found1, busy2, done2, found2;
  logic [CW-1:0] xmn1, xmx1, ymn1, ymx1, xmn2, xmx2, ymn2, ymx2;

  bit mem [N];

  always @(posedge clk) rd1 <= mem[addr1];
  always @(posedge clk) begin
    rd2a <= mem[addr2];
    rd2b <= rd2a;
  end

  bw_bbox_scanner #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .COORD_W(CW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .ack(ack1), .rd_addr(addr1), .rd_data(rd1),
    .busy(busy1), .done(done1), .found(found1),
    .x_min(xmn1), .x_max(xmx1), .y_min(ymn1), .y_max(ymx1));

  bw_bbox_scanner #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .COORD_W(CW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .ack(ack2), .rd_addr(addr2), .rd_data(rd2b),
    .busy(busy2), .done(done2), .found(found2),
    .x_min(xmn2), .x_max(xmx2), .y_min(ymn2), .y_max(ymx2));

  typedef struct {
    logic [31:0] found, xmin, xmax, ymin, ymax;
  } res_t;

  typedef struct {
    res_t r;
    int   lat;
  } exp_t;

  exp_t sb[$];
  res_t last_res [3];
  int   sel = 1;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic res_t zero_res();
    res_t r;
    r.found = 0; r.xmin = 0; r.xmax = 0; r.ymin = 0; r.ymax = 0;
    return r;
  endfunction

  function automatic res_t model();
    res_t r;
    int xa = W, xb = -1, ya = H, yb = -1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (mem[y*W + x]) begin
          if (x < xa) xa = x;
          if (x > xb) xb = x;
          if (y < ya) ya = y;
          if (y > yb) yb = y;
        end
    if (xb < 0) return zero_res();
    r.found = 1; r.xmin = xa; r.xmax = xb; r.ymin = ya; r.ymax = yb;
    return r;
  endfunction

  function automatic res_t cur_out();
    res_t r;
    if (sel == 1) begin
      r.found = 32'(found1); r.xmin = 32'(xmn1); r.xmax = 32'(xmx1); r.ymin = 32'(ymn1); r.ymax = 32'(ymx1);
    end else begin
      r.found = 32'(found2); r.xmin = 32'(xmn2); r.xmax = 32'(xmx2); r.ymin = 32'(ymn2); r.ymax = 32'(ymx2);
    end
    return r;
  endfunction

  function automatic logic f_busy(); return (sel == 1) ? busy1 : busy2; endfunction
  function automatic logic f_done(); return (sel == 1) ? done1 : done2; endfunction
  function automatic logic [31:0] f_addr(); return (sel == 1) ? 32'(addr1) : 32'(addr2); endfunction

  task automatic set_start(input logic v);
    if (sel == 1) start1 = v; else start2 = v;
  endtask

  task automatic set_ack(input logic v);
    if (sel == 1) ack1 = v; else ack2 = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 1'b0;
  endtask

  task automatic check_res(input string tag, input res_t got, input res_t exp);
    check_eq({tag, "_found"}, got.found, exp.found);
    check_eq({tag, "_xmin"},  got.xmin,  exp.xmin);
    check_eq({tag, "_xmax"},  got.xmax,  exp.xmax);
    check_eq({tag, "_ymin"},  got.ymin,  exp.ymin);
    check_eq({tag, "_ymax"},  got.ymax,  exp.ymax);
  endtask

  task automatic run_scan(input string name, input bit poke_start);
    exp_t e;
    res_t got;
    int cnt, busy_cnt, bad_step;
    logic [31:0] a, prev, maxa;
    e.r   = model();
    e.lat = N + sel + 1;
    sb.push_back(e);
    @(negedge clk) set_start(1'b1);
    @(negedge clk) set_start(1'b0);
    cnt = 0; busy_cnt = 0; bad_step = 0;
    prev = f_addr(); maxa = prev;
    check_eq({name, "_addr0"}, f_addr(), 0);
    while (!f_done() && cnt < 200) begin
      if (f_busy()) busy_cnt++;
      if (cnt == 12) check_res({name, "_hold"}, cur_out(), last_res[sel]);
      if (poke_start && cnt == 5) set_start(1'b1);
      if (poke_start && cnt == 6) set_start(1'b0);
      @(negedge clk);
      cnt++;
      a = f_addr();
      if (a != prev && a != prev + 1) bad_step++;
      if (a > maxa) maxa = a;
      prev = a;
    end
    e = sb.pop_front();
    got = cur_out();
    check_eq({name, "_latency"}, cnt, e.lat);
    check_eq({name, "_busy_cycles"}, busy_cnt, e.lat);
    check_eq({name, "_busy_at_done"}, 32'(f_busy()), 0);
    check_eq({name, "_addr_max"}, maxa, N - 1);
    check_eq({name, "_addr_steps"}, bad_step, 0);
    check_res(name, got, e.r);
    last_res[sel] = e.r;
    $display("scan %s sel=%0d: done@%0d found=%0d box=%0d/%0d/%0d/%0d", name, sel, cnt,
             got.found, got.xmin, got.xmax, got.ymin, got.ymax);
  endtask

  task automatic hold_done(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (i == 3) set_start(1'b1);
      if (i == 4) set_start(1'b0);
      @(negedge clk);
      check_eq("hold_done", 32'(f_done()), 1);
      check_eq("hold_busy", 32'(f_busy()), 0);
      check_eq("hold_xmin", cur_out().xmin, last_res[sel].xmin);
    end
  endtask

  task automatic do_ack(input bit with_start);
    @(negedge clk);
    set_ack(1'b1);
    if (with_start) set_start(1'b1);
    @(negedge clk);
    set_ack(1'b0);
    set_start(1'b0);
    check_eq("ack_done_fall", 32'(f_done()), 0);
    if (with_start) begin
      check_eq("ack_start_busy", 32'(f_busy()), 0);
      @(negedge clk);
      check_eq("ack_start_idle", 32'(f_busy() | f_done()), 0);
    end
  endtask

  initial begin
    last_res[0] = zero_res();
    last_res[1] = zero_res();
    last_res[2] = zero_res();
    clear_mem();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",  32'(busy1), 0);
    check_eq("rst_done",  32'(done1), 0);
    check_eq("rst_addr",  32'(addr1), 0);
    check_res("rst", cur_out(), zero_res());
    reset_n = 1'b1;

    sel = 1;
    clear_mem(); mem[21] = 1'b1;
    run_scan("single", 1'b1);
    hold_done(10);
    do_ack(1'b0);

    clear_mem();
    run_scan("empty", 1'b0);
    do_ack(1'b1);

    clear_mem(); mem[1*W+2] = 1'b1; mem[2*W+6] = 1'b1;
    run_scan("btb_a", 1'b0);
    do_ack(1'b0);
    clear_mem(); mem[3*W+1] = 1'b1;
    run_scan("btb_b", 1'b0);
    do_ack(1'b0);

    clear_mem(); mem[1*W+3] = 1'b1;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy1), 0);
    check_eq("midrst_addr", 32'(addr1), 0);
    check_eq("midrst_done", 32'(done1), 0);
    check_res("midrst", cur_out(), zero_res());
    last_res[1] = zero_res();
    last_res[2] = zero_res();
    @(negedge clk) reset_n = 1'b1;
    run_scan("after_rst", 1'b0);
    do_ack(1'b0);

    sel = 2;
    clear_mem(); mem[0] = 1'b1; mem[N-1] = 1'b1;
    run_scan("corners", 1'b0);
    do_ack(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
